reglist_sequencer: RTL
======================

# reglist_sequencer

Multi-register transfer controller for the core: sequences PUSH/POP/LDM/STM by walking a 9-bit register list, issuing one 32-bit memory access per listed register and driving the core register file's read and write ports. It sits between the instruction decoder, the core register file and the data-memory port. During a transfer it owns the register-file write port (`ld_rd`, `ld_pc`). It is the only block that iterates over registers.

## Interface
No parameters (data width fixed at 32, list width fixed at 9).
- `clk`  in  1  core clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted at 0)
- `start`  in  1  request pulse; sampled only in IDLE
- `is_load`  in  1  1 = LDM/POP (memory→regs), 0 = STM/PUSH (regs→memory)
- `decr_before`  in  1  1 = PUSH addressing (first address = base − 4·count)
- `writeback`  in  1  update base register at end
- `base_reg`  in  4  base register index (SP = 13 for PUSH/POP)
- `base_addr`  in  32  base register value
- `reg_list`  in  9  bits 0–7 = R0–R7; bit 8 = LR (store) / PC (load)
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle
- `done`  out  1  one-cycle pulse at completion
- `err`  out  1  one-cycle pulse with `done` on illegal request
- `mem_req` / `mem_we`  out  1/1  access request / write strobe
- `mem_addr` / `mem_wdata`  out  32/32  word address, store data
- `mem_ack`  in  1  access complete, sampled on rising edge while `mem_req`=1
- `mem_rdata`  in  32  load data, valid when `mem_ack`=1
- `rd_addr`  out  4  register-file read index (store source)
- `rd_data`  in  32  register-file read data
- `wr_addr` / `wr_data` / `ld_rd`  out  4/32/1  register-file write port
- `pc_wdata` / `ld_pc`  out  32/1  PC write port (POP {PC})

## Operation
- States: IDLE, XFER, WB, DONE.
- IDLE: on `start`=1, latch `is_load`, `decr_before`, `writeback`, `base_reg`, `base_addr` and `reg_list` into `remain`; `count` = popcount(`reg_list`) (0–9).
  - Next address = `base_addr` − 4·`count` if `decr_before`, else `base_addr`.
  - If `reg_list`==0 or `base_addr[1:0]`≠0: go to DONE with `err` flagged. No memory access and no register writes occur.
- XFER: current register = lowest set bit of `remain`; bit 8 maps to index 14 (store) or 15 (load).
  - `mem_req`=1, `mem_addr`=address, `mem_we`=~`is_load`.
  - Store: `rd_addr`=current index, `mem_wdata`=`rd_data`.
  - Outputs stay stable until `mem_ack`.
  - On ack: clear that bit, address += 4.
  - Load bits 0–7: `ld_rd`=1 in the ack cycle, `wr_addr`=index, `wr_data`=`mem_rdata`.
  - Load bit 8: `ld_pc`=1, `pc_wdata`={`mem_rdata`[31:1],1'b0}.
  - When `remain` becomes 0: go to WB if `writeback` and not (load with `base_reg` in list); else go to DONE.
- WB: one cycle with `ld_rd`=1, `wr_addr`=`base_reg`, `wr_data`=`base_addr` − 4·`count` (`decr_before`) or `base_addr` + 4·`count`. Then go to DONE.
- DONE: `done`=1 (with `err` if flagged), then return to IDLE.
- Address arithmetic is modulo 2^32; wrap is not an error.

## Timing
- Reset values: all outputs 0, state IDLE, `remain`=0. Reset mid-transfer drops `mem_req`, `ld_rd` and `ld_pc` immediately; a partial transfer is abandoned with no WB.
- `start` accepted at edge 0 → `busy` and first `mem_req` in cycle 1.
- With zero-wait ack, k registers take cycles 1..k; WB in cycle k+1 if taken; `done` in the following cycle.
- `start` while `busy` is ignored. `start` in the DONE cycle is ignored (state is not IDLE).
- `ld_rd` and `ld_pc` are never asserted in the same cycle. At most one register write occurs per cycle.
- `mem_req` never deasserts before `mem_ack`. Stall length is unbounded.

## Structure
- Shared core package holds:
  - state enum `seq_state_t`
  - `REG_SP`=13, `REG_LR`=14, `REG_PC`=15
  - list width 9 and word size 4
- One sub-module, `reglist_prienc`: combinational lowest-set-bit index (4-bit, with valid) plus popcount of the 9-bit list. It is used for both the initial `count` and per-step selection.

## Test plan
- PUSH {R0,R2,LR}, base SP=0x1000, `decr_before`=1, `writeback`=1, ack every cycle:
  - stores to 0x0FF4 (R0), 0x0FF8 (R2), 0x0FFC (R14)
  - then `ld_rd` with `wr_addr`=13, `wr_data`=0x0FF4; `done` in cycle 5
- POP {R1,PC}, base 0x0FF8, `writeback`=1, `mem_rdata`=0x11, then 0x2001:
  - R1←0x11
  - `ld_pc` with `pc_wdata`=0x2000
  - SP←0x1000
- LDM R3!,{R3,R4}, base 0x2000: loads 0x2000→R3, 0x2004→R4; writeback suppressed (no third `ld_rd`).
- STM with 3-cycle `mem_ack` stall per beat: `mem_addr`/`mem_wdata` held constant throughout each stall; `busy` held high; `start` pulses during transfer ignored.
- `reg_list`=0, and separately `base_addr`=0x1002: `err`+`done` at cycle 1; no `mem_req` or `ld_rd` ever asserted.
- Reset (`rst`=0) while second beat of a 4-register STM is stalled: `mem_req` falls without waiting for a clock edge; after release, IDLE with `busy`=0; next `start` proceeds normally.

Source files
------------

// File: rtl/reglist_sequencer_pkg.sv
// Shared definitions for the multi-register transfer sequencer:
// FSM states, architectural register indices and list geometry.
package reglist_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam logic [3:0] REG_SP     = 4'd13;
  localparam logic [3:0] REG_LR     = 4'd14;
  localparam logic [3:0] REG_PC     = 4'd15;
  localparam int         LIST_W     = 9;
  localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/reglist_sequencer_prienc.sv
// Lowest-set-bit index and popcount of a register list; purely combinational.
module reglist_prienc
  import reglist_sequencer_pkg::*;
(
  input  logic [LIST_W-1:0] list_i,
  output logic [3:0]        idx_o,
  output logic              valid_o,
  output logic [3:0]        count_o
);

  // Scanning high to low leaves the lowest set bit as the final index.
  always_comb begin
    idx_o   = 4'd0;
    valid_o = 1'b0;
    count_o = 4'd0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list_i[i]) begin
        idx_o   = 4'(i);
        valid_o = 1'b1;
        count_o = count_o + 4'd1;
      end
    end
  end

endmodule

// File: rtl/reglist_sequencer.sv
// PUSH/POP/LDM/STM sequencer: one word access per listed register, then an
// optional base writeback. Handshake: mem_req holds address/data until mem_ack.
module reglist_sequencer
  import reglist_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        decr_before,
  input  logic        writeback,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_addr,
  input  logic [8:0]  reg_list,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic [3:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        ld_rd,
  output logic [31:0] pc_wdata,
  output logic        ld_pc,
  output logic [1:0]  dbg_state
);

  seq_state_t        state_q;
  logic [LIST_W-1:0] remain_q;
  logic [31:0]       addr_q;
  logic [31:0]       wb_val_q;
  logic              is_load_q;
  logic              take_wb_q;
  logic              err_q;
  logic [3:0]        base_reg_q;

  logic [LIST_W-1:0] pe_list;
  logic [3:0]        pe_idx;
  logic              pe_valid;
  logic [3:0]        pe_count;

  // The encoder sees the incoming list in IDLE and the remaining list otherwise.
  assign pe_list = (state_q == ST_IDLE) ? reg_list : remain_q;

  reglist_prienc u_prienc (
    .list_i  (pe_list),
    .idx_o   (pe_idx),
    .valid_o (pe_valid),
    .count_o (pe_count)
  );

  logic [31:0]       span;
  logic [31:0]       low_addr;
  logic              base_in_list;
  logic              bad_req;
  logic [3:0]        cur_idx;
  logic [LIST_W-1:0] remain_next;
  logic              xfer;
  logic              beat_done;
  logic              ld_mem_rd;

  assign span         = 32'(pe_count) * 32'(WORD_BYTES);
  assign low_addr     = base_addr - span;
  assign base_in_list = (base_reg < 4'd8) ? reg_list[base_reg[2:0]]
                                          : ((base_reg == REG_PC) && reg_list[8]);
  assign bad_req      = (reg_list == '0) || (base_addr[1:0] != 2'b00);
  assign cur_idx      = pe_idx[3] ? (is_load_q ? REG_PC : REG_LR) : pe_idx;
  assign remain_next  = remain_q & ~(LIST_W'(1) << pe_idx);
  assign xfer         = (state_q == ST_XFER);
  assign beat_done    = xfer && mem_ack && pe_valid;
  assign ld_mem_rd    = beat_done && is_load_q && !pe_idx[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      remain_q   <= '0;
      addr_q     <= '0;
      wb_val_q   <= '0;
      is_load_q  <= 1'b0;
      take_wb_q  <= 1'b0;
      err_q      <= 1'b0;
      base_reg_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            is_load_q  <= is_load;
            base_reg_q <= base_reg;
            addr_q     <= decr_before ? low_addr : base_addr;
            wb_val_q   <= decr_before ? low_addr : (base_addr + span);
            take_wb_q  <= writeback && !(is_load && base_in_list);
            if (bad_req) begin
              err_q    <= 1'b1;
              remain_q <= '0;
              state_q  <= ST_DONE;
            end else begin
              err_q    <= 1'b0;
              remain_q <= reg_list;
              state_q  <= ST_XFER;
            end
          end
        end
        ST_XFER: begin
          if (beat_done) begin
            remain_q <= remain_next;
            addr_q   <= addr_q + 32'(WORD_BYTES);
            if (remain_next == '0) begin
              state_q <= take_wb_q ? ST_WB : ST_DONE;
            end
          end
        end
        ST_WB: begin
          state_q <= ST_DONE;
        end
        default: begin
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err       = done && err_q;
  assign dbg_state = state_q;

  assign mem_req   = xfer;
  assign mem_we    = xfer && !is_load_q;
  assign mem_addr  = xfer ? addr_q : 32'd0;
  assign rd_addr   = (xfer && !is_load_q) ? cur_idx : 4'd0;
  assign mem_wdata = (xfer && !is_load_q) ? rd_data : 32'd0;

  // Register-file writes come either from a load ack or from the WB cycle.
  assign ld_rd    = (state_q == ST_WB) || ld_mem_rd;
  assign wr_addr  = (state_q == ST_WB) ? base_reg_q : (ld_mem_rd ? cur_idx : 4'd0);
  assign wr_data  = (state_q == ST_WB) ? wb_val_q : (ld_mem_rd ? mem_rdata : 32'd0);
  assign ld_pc    = beat_done && is_load_q && pe_idx[3];
  assign pc_wdata = ld_pc ? {mem_rdata[31:1], 1'b0} : 32'd0;

endmodule
